keypad_scan: RTL and testbench
==============================

Name: keypad_scan

Overview:
- Upstream front end for the phone-charging controller.
- Scans a 4x4 active-low key matrix, synchronises and debounces the column inputs, and encodes the pressed key.
- Drives the controller's key interface: num, start, clear, enter, plus the startSet level. The controller acts on the rising edge of startSet and samples the codes on that same press.
- One clean rising edge of startSet per physical key press. Codes are stable for as long as startSet is high.

Parameters:
SCAN_DIV, 250, clock cycles each row is driven (dwell); must be >= 3
DEBOUNCE, 4, consecutive identical frame results needed to accept a press or a release; must be >= 1

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
col_n  in  4  matrix column inputs, active-low (pulled up), asynchronous
row_n  out  4  matrix row drive, one-hot low
num  out  5  digit 0..9; 5'h1F when no digit is held
start  out  1  high while key A is held (accepted)
clear  out  1  high while key B is held (accepted)
enter  out  1  high while key C is held (accepted)
startSet  out  1  high while any accepted key is held

Behaviour:
- Reset (async, RST_N low):
  - row_n=4'b1110, row index 0, dwell counter 0.
  - startSet=0, num=5'h1F, start=clear=enter=0.
  - FSM=IDLE, synchronisers and frame accumulator cleared.
  - Outputs go idle immediately on assertion, including mid-press.
- Scan:
  - col_n passes through a 2-FF synchroniser.
  - The dwell counter runs 0..SCAN_DIV-1. At SCAN_DIV-1 the row index advances 0->1->2->3->0 and row_n = ~(1<<row).
  - The synchronised columns are sampled on the dwell-final cycle of each row; SCAN_DIV>=3 absorbs sync latency.
  - Frame = 4*SCAN_DIV cycles. It ends at the dwell-final cycle of row 3 and produces a one-cycle frame_done pulse on the next cycle.
- Key index = row*4+col. Map:
  - 0:'1' 1:'2' 2:'3' 3:A
  - 4:'4' 5:'5' 6:'6' 7:B
  - 8:'7' 9:'8' 10:'9' 11:C
  - 12:'*' 13:'0' 14:'#' 15:D
  - '*', '#' and D are unmapped and treated as not pressed.
- Frame result: the lowest-index mapped key seen low during the frame, else NONE. Multiple keys resolve to the lowest index.
- FSM (acts only on frame_done; cnt is 3-bit or wider, sized for DEBOUNCE):
  - IDLE: key k -> cand=k, cnt=1. Go to HELD if DEBOUNCE==1, else DB_PRESS. NONE -> stay.
  - DB_PRESS: same k -> cnt+1; when cnt reaches DEBOUNCE -> HELD. Different key -> cand=new, cnt=1. NONE -> IDLE.
  - HELD: NONE -> cnt=1. Go to IDLE if DEBOUNCE==1, else DB_REL. Any key, including a different one -> stay; no new press is reported.
  - DB_REL: NONE -> cnt+1; when cnt reaches DEBOUNCE -> IDLE. Any key -> HELD.
- Output rules:
  - On entry to HELD from DB_PRESS or IDLE, on the same edge: startSet=1 and codes from cand.
    - digit: num=value, start/clear/enter=0.
    - A/B/C: num=5'h1F and the matching flag=1.
  - Codes and startSet are held unchanged through HELD and DB_REL.
  - On entry to IDLE from DB_REL, on the same edge: startSet=0 and codes idle.
  - At most one of start/clear/enter is high at a time. num<10 only when no flag is high.
- Latency: a key stable across whole frames gives startSet rising 1 cycle after the frame_done of the DEBOUNCE-th matching frame. Release latency is symmetric.

Test Plan (SCAN_DIV=3, DEBOUNCE=2, frame=12 cycles):
1. Hold '7' (row2,col0) for 4 frames from reset release -> num=7 and startSet rises after the 2nd full frame. start=clear=enter=0 throughout. row_n cycles 1110,1101,1011,0111 every 3 cycles.
2. Release after case 1 -> startSet falls 2 frames later, num=5'h1F. Exactly one rising edge of startSet in total.
3. Key '5' toggling pressed/released every frame for 8 frames -> startSet stays 0, num stays 5'h1F.
4. Hold A, release, then hold C -> start=1/num=1F during the first press and enter=1 during the second; two startSet pulses, separated by a low period.
5. '1' and '5' pressed together -> num=1. Adding '9' while '1' is held -> num stays 1, no new startSet edge.
6. Assert RST_N low while HELD with '3' -> startSet=0, num=1F, row_n=1110 immediately; '*' held afterwards -> startSet never rises.

Source files
------------

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 active-low key matrix scanner with column synchronisation,
// per-frame lowest-index key resolution, press/release debounce and key
// encoding for the charging-controller key interface.
module keypad_scan #(
  parameter int unsigned SCAN_DIV = 250,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [4:0] num,
  output logic       start,
  output logic       clear,
  output logic       enter,
  output logic       startSet
);

  localparam int unsigned DW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CWR = $clog2(DEBOUNCE + 1);
  localparam int unsigned CW  = (CWR < 3) ? 3 : CWR;

  typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_REL} state_t;

  state_t          state;
  logic [DW-1:0]   dwell;
  logic [1:0]      row;
  logic [3:0]      col_s1, col_s2;
  logic            acc_vld;
  logic [3:0]      acc_key;
  logic            frame_done;
  logic            frame_vld;
  logic [3:0]      frame_key;
  logic [3:0]      cand;
  logic [CW-1:0]   cnt;
  logic            dwell_last;
  logic            row_hit;
  logic [1:0]      row_col;
  logic [1:0]      next_row;
  logic [4:0]      dec_num;
  logic [2:0]      dec_flags;

  assign dwell_last = (dwell == DW'(SCAN_DIV - 1));
  assign next_row   = row + 2'd1;

  // '*', '#' and D never count as pressed
  function automatic logic is_mapped(input logic [3:0] k);
    return !((k == 4'd12) || (k == 4'd14) || (k == 4'd15));
  endfunction

  // Two-flop synchroniser on the asynchronous column inputs (idle = released)
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      col_s1 <= '1;
      col_s2 <= '1;
    end else begin
      col_s1 <= col_n;
      col_s2 <= col_s1;
    end
  end

  // Lowest-numbered mapped column pulled low on the currently driven row
  always_comb begin
    row_hit = 1'b0;
    row_col = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      if (!row_hit && !col_s2[c] && is_mapped({row, 2'(c)})) begin
        row_hit = 1'b1;
        row_col = 2'(c);
      end
    end
  end

  // Row dwell timing, row drive and frame accumulation; rows are scanned in
  // ascending order so the first hit in a frame is the lowest key index
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dwell      <= '0;
      row        <= '0;
      row_n      <= 4'b1110;
      acc_vld    <= 1'b0;
      acc_key    <= '0;
      frame_done <= 1'b0;
      frame_vld  <= 1'b0;
      frame_key  <= '0;
    end else begin
      frame_done <= 1'b0;
      if (dwell_last) begin
        dwell <= '0;
        row   <= next_row;
        row_n <= ~(4'b0001 << next_row);
        if (row == 2'd3) begin
          frame_done <= 1'b1;
          frame_vld  <= acc_vld | row_hit;
          frame_key  <= acc_vld ? acc_key : {row, row_col};
          acc_vld    <= 1'b0;
          acc_key    <= '0;
        end else if (!acc_vld && row_hit) begin
          acc_vld <= 1'b1;
          acc_key <= {row, row_col};
        end
      end else begin
        dwell <= dwell + DW'(1);
      end
    end
  end

  // Encode the frame result into controller codes
  always_comb begin
    dec_num   = 5'h1F;
    dec_flags = 3'b000;
    case (frame_key)
      4'd3:  dec_flags = 3'b100;
      4'd7:  dec_flags = 3'b010;
      4'd11: dec_flags = 3'b001;
      4'd13: dec_num   = 5'd0;
      4'd12, 4'd14, 4'd15: dec_num = 5'h1F;
      default: dec_num = 5'(frame_key[3:2]) * 5'd3 + 5'(frame_key[1:0]) + 5'd1;
    endcase
  end

  // Debounce FSM with registered key outputs, updated once per frame.
  // Codes load from the current frame result, which equals cand on entry to HELD.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      cand     <= '0;
      cnt      <= '0;
      startSet <= 1'b0;
      num      <= 5'h1F;
      start    <= 1'b0;
      clear    <= 1'b0;
      enter    <= 1'b0;
    end else if (frame_done) begin
      case (state)
        IDLE: begin
          if (frame_vld) begin
            cand <= frame_key;
            cnt  <= CW'(1);
            if (DEBOUNCE == 1) begin
              state                 <= HELD;
              startSet              <= 1'b1;
              num                   <= dec_num;
              {start, clear, enter} <= dec_flags;
            end else begin
              state <= DB_PRESS;
            end
          end
        end
        DB_PRESS: begin
          if (!frame_vld) begin
            state <= IDLE;
          end else if (frame_key == cand) begin
            cnt <= cnt + CW'(1);
            if (cnt + CW'(1) >= CW'(DEBOUNCE)) begin
              state                 <= HELD;
              startSet              <= 1'b1;
              num                   <= dec_num;
              {start, clear, enter} <= dec_flags;
            end
          end else begin
            cand <= frame_key;
            cnt  <= CW'(1);
          end
        end
        HELD: begin
          if (!frame_vld) begin
            cnt <= CW'(1);
            if (DEBOUNCE == 1) begin
              state                 <= IDLE;
              startSet              <= 1'b0;
              num                   <= 5'h1F;
              {start, clear, enter} <= 3'b000;
            end else begin
              state <= DB_REL;
            end
          end
        end
        DB_REL: begin
          if (frame_vld) begin
            state <= HELD;
          end else begin
            cnt <= cnt + CW'(1);
            if (cnt + CW'(1) >= CW'(DEBOUNCE)) begin
              state                 <= IDLE;
              startSet              <= 1'b0;
              num                   <= 5'h1F;
              {start, clear, enter} <= 3'b000;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: scoreboard bench for keypad_scan with SCAN_DIV=3, DEBOUNCE=2.
// Stimulus pushes expected startSet edges; a monitor pops them on each edge.
module tb_keypad_scan;

  localparam int unsigned FRAME = 12;

  logic       clk;
  logic       rst_n;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [4:0] num;
  logic       start, clear, enter, startSet;
  logic [15:0] keys;
  int         cyc;
  int         checks;
  int         failures;

  typedef struct {
    bit         rise;
    logic [4:0] num;
    logic [2:0] flags;
    int         cyc;
  } ev_t;

  ev_t        exp_q[$];
  logic [4:0] held_num;
  logic [2:0] held_flags;
  logic       prev_ss;

  keypad_scan #(.SCAN_DIV(3), .DEBOUNCE(2)) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .col_n    (col_n),
    .row_n    (row_n),
    .num      (num),
    .start    (start),
    .clear    (clear),
    .enter    (enter),
    .startSet (startSet)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ideal matrix: a column reads low when a pressed key sits on a driven row
  always_comb begin
    col_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cyc=%0d t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  task automatic push(input bit rise, input logic [4:0] n, input logic [2:0] f, input int c);
    ev_t e;
    e.rise = rise; e.num = n; e.flags = f; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic wait_frames(input int n);
    repeat (n * FRAME) @(negedge clk);
  endtask

  // Monitor: row sequence, startSet edges against the queue, code stability
  initial begin
    ev_t e;
    prev_ss    = 1'b0;
    held_num   = 5'h1F;
    held_flags = 3'b000;
    forever begin
      @(negedge clk);
      if (rst_n)
        chk("row_n", row_n, ~(4'b0001 << ((cyc / 3) % 4)) & 4'hF);
      if (startSet !== prev_ss) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_startSet_edge", startSet, prev_ss);
        end else begin
          e = exp_q.pop_front();
          chk("edge_dir", startSet, e.rise);
          if (e.cyc >= 0) chk("edge_cycle", cyc, e.cyc);
          held_num   = e.rise ? e.num : 5'h1F;
          held_flags = e.rise ? e.flags : 3'b000;
        end
        prev_ss = startSet;
      end
      if (startSet) begin
        chk("held_num", num, held_num);
        chk("held_flags", {start, clear, enter}, held_flags);
      end else begin
        chk("idle_num", num, 5'h1F);
        chk("idle_flags", {start, clear, enter}, 3'b000);
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    keys     = '0;
    keys[8]  = 1'b1;                    // '7'
    repeat (3) @(negedge clk);
    chk("rst_row_n", row_n, 4'b1110);
    chk("rst_startSet", startSet, 0);
    chk("rst_num", num, 5'h1F);
    chk("rst_flags", {start, clear, enter}, 0);

    // 1/2: hold '7' four frames, release
    push(1'b1, 5'd7, 3'b000, 25);
    push(1'b0, 5'h1F, 3'b000, 73);
    rst_n = 1'b1;                       // cyc 0 at this negedge
    wait_frames(4);
    keys = '0;
    wait_frames(3);                     // cyc 84

    // 3: '5' bouncing every frame never accepted
    for (int i = 0; i < 8; i++) begin
      keys    = '0;
      keys[5] = (i % 2 == 0);
      wait_frames(1);
    end                                 // cyc 180
    chk("bounce_startSet", startSet, 0);
    chk("bounce_num", num, 5'h1F);

    // 4: A then C, separate presses
    push(1'b1, 5'h1F, 3'b100, 205);
    push(1'b0, 5'h1F, 3'b000, 241);
    push(1'b1, 5'h1F, 3'b001, 277);
    push(1'b0, 5'h1F, 3'b000, 313);
    keys = '0; keys[3] = 1'b1;
    wait_frames(3);
    keys = '0;
    wait_frames(3);
    keys[11] = 1'b1;
    wait_frames(3);
    keys = '0;
    wait_frames(3);                     // cyc 324

    // 5: '1'+'5' resolve to '1'; adding '9' changes nothing
    push(1'b1, 5'd1, 3'b000, 349);
    push(1'b0, 5'h1F, 3'b000, 409);
    keys[0] = 1'b1; keys[5] = 1'b1;
    wait_frames(3);
    chk("multi_num", num, 5'd1);
    keys[10] = 1'b1;
    wait_frames(2);
    chk("add9_num", num, 5'd1);
    chk("add9_startSet", startSet, 1);
    keys = '0;
    wait_frames(3);                     // cyc 420

    // 6: reset while holding '3', then '*' held is ignored
    push(1'b1, 5'd3, 3'b000, 445);
    push(1'b0, 5'h1F, 3'b000, -1);
    keys[2] = 1'b1;
    wait_frames(3);
    chk("pre_rst_startSet", startSet, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_startSet", startSet, 0);
    chk("async_rst_num", num, 5'h1F);
    chk("async_rst_row_n", row_n, 4'b1110);
    keys = '0; keys[12] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_frames(4);
    chk("star_startSet", startSet, 0);
    chk("star_num", num, 5'h1F);
    keys = '0;
    wait_frames(1);
    chk("events_left", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
